serial_comparator_ctrl: RTL and testbench

Sequential magnitude comparator for WIDTH-bit unsigned operands. It walks the operands two bits at a time, most significant pair first, through one shared 2-bit compare stage. A small FSM with a start/done handshake sequences the stage. It is the controller the team uses wherever wide comparisons must share a single 2-bit comparator instead of instantiating a full-width one.

---
 rtl/serial_comparator_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_comparator_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_ctrl.sv
// Sequential WIDTH-bit unsigned magnitude comparator: one shared 2-bit compare
// stage walks the operands MSB pair first. Define SERCMP_EARLY_EXIT_EN to finish
// on the first unequal digit; otherwise every comparison runs all D digits.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater,
  output logic             A_equal,
  output logic             A_less
);

  localparam int D     = WIDTH / 2;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(D - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [IDX_W-1:0] idx;
  logic [1:0]       dig_a, dig_b;

`ifndef SERCMP_EARLY_EXIT_EN
  // First unequal digit seen so far, and whether A won it.
  logic decided, dec_gt;
`endif

  // Shared 2-bit stage input: digit idx of each latched operand.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < D; i++) begin
      if (idx == IDX_W'(i)) begin
        dig_a = op_a[2*i +: 2];
        dig_b = op_b[2*i +: 2];
      end
    end
  end

  // NOTE: all state, including the operand registers, is reset and updated with <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A_greater <= 1'b0;
      A_equal   <= 1'b0;
      A_less    <= 1'b0;
`ifndef SERCMP_EARLY_EXIT_EN
      decided   <= 1'b0;
      dec_gt    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= A;
            op_b      <= B;
            idx       <= IDX_MSB;
            A_greater <= 1'b0;
            A_equal   <= 1'b0;
            A_less    <= 1'b0;
            busy      <= 1'b1;
            state     <= COMPARE;
`ifndef SERCMP_EARLY_EXIT_EN
            decided   <= 1'b0;
            dec_gt    <= 1'b0;
`endif
          end
        end

        COMPARE: begin
`ifdef SERCMP_EARLY_EXIT_EN
          if (dig_a != dig_b || idx == '0) begin
            A_greater <= (dig_a > dig_b);
            A_less    <= (dig_a < dig_b);
            A_equal   <= (dig_a == dig_b);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          if (idx == '0) begin
            // A more significant difference outranks whatever the last digit says.
            if (decided) begin
              A_greater <= dec_gt;
              A_less    <= !dec_gt;
            end else begin
              A_greater <= (dig_a > dig_b);
              A_less    <= (dig_a < dig_b);
              A_equal   <= (dig_a == dig_b);
            end
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (!decided && dig_a != dig_b) begin
              decided <= 1'b1;
              dec_gt  <= (dig_a > dig_b);
            end
            idx <= idx - 1'b1;
          end
`endif
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Scoreboard bench for serial_comparator_ctrl (WIDTH=8); expected latency follows
// SERCMP_EARLY_EXIT_EN when the bench is built with the same define.
`timescale 1ns/1ps
module tb_serial_comparator_ctrl;

  localparam int WIDTH = 8;
  localparam int D     = WIDTH / 2;
`ifdef SERCMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk, rst_n, start;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, A_greater, A_equal, A_less;

  serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .A_greater (A_greater),
    .A_equal   (A_equal),
    .A_less    (A_less)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  typedef struct {
    logic [2:0] flags;        // {gt, eq, lt}
    int         accept_edge;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: scan digits MSB first; the first unequal digit decides.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int acc, input string nm);
    exp_t     e;
    bit       found = 1'b0;
    int       k     = D;
    logic [1:0] da, db;
    e.flags = 3'b010;
    for (int i = D - 1; i >= 0; i--) begin
      da = a[2*i +: 2];
      db = b[2*i +: 2];
      if (!found && da != db) begin
        found   = 1'b1;
        k       = D - i;
        e.flags = (da > db) ? 3'b100 : 3'b001;
      end
    end
    e.lat         = EARLY ? k : D;
    e.accept_edge = acc;
    e.name        = nm;
    return e;
  endfunction

  // Called at a negedge: the following posedge accepts the request.
  task automatic push_accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input string nm);
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(model(a, b, edge_cnt + 1, nm));
  endtask

  task automatic check_pop();
    exp_t e;
    int   lat;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_done: got done=1 with no request outstanding, want done=0");
    end else begin
      e   = sb.pop_front();
      lat = edge_cnt - e.accept_edge;
      if ({A_greater, A_equal, A_less} !== e.flags || lat != e.lat || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: got gt/eq/lt=%b lat=%0d busy=%b, want gt/eq/lt=%b lat=%0d busy=0",
                 e.name, {A_greater, A_equal, A_less}, lat, busy, e.flags, e.lat);
      end
    end
  endtask

  // Leaves start low after acceptance, scrambles A/B, and waits for the done pulse.
  task automatic wait_done(input string nm);
    bit         got = 1'b0;
    logic [2:0] held;
    for (int c = 0; c < 3 * D && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        check_pop();
      end else begin
        n_checks++;
        if (busy !== 1'b1 || {A_greater, A_equal, A_less} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s_busy_window: got busy=%b flags=%b, want busy=1 flags=000",
                   nm, busy, {A_greater, A_equal, A_less});
        end
      end
      if (c == 0) begin
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, want done", nm, 3 * D);
      sb.delete();
    end
    held = {A_greater, A_equal, A_less};
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {A_greater, A_equal, A_less} !== held) begin
      n_fail++;
      $display("FAIL %s_after_done: got done=%b busy=%b flags=%b, want done=0 busy=0 flags=%b",
               nm, done, busy, {A_greater, A_equal, A_less}, held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    A     = 8'h40;
    B     = 8'h80;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, A_greater, A_equal, A_less} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got busy/done/flags=%b, want 00000",
                 {busy, done, A_greater, A_equal, A_less});
      end
    end
    rst_n = 1'b1;
    push_accept(8'h40, 8'h80, "reset_first_accept");
    wait_done("reset_first_accept");
  endtask

  task automatic test_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input string nm);
    push_accept(a, b, nm);
    wait_done(nm);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom);
      b = (i % 3 == 0) ? a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : WIDTH'($urandom);
      test_single(a, b, $sformatf("random_%0d", i));
    end
  endtask

  // start held high with fresh operands every cycle; accepts predicted k+2 apart.
  task automatic test_back_to_back();
    int  accepts  = 0;
    int  dones    = 0;
    bit  can_push = 1'b1;
    bit  idle_nxt = 1'b0;
    logic [WIDTH-1:0] a, b;
    for (int c = 0; c < 200 && !(accepts == 6 && sb.size() == 0); c++) begin
      a     = WIDTH'($urandom);
      b     = (c % 4 == 0) ? a : WIDTH'($urandom);
      A     = a;
      B     = b;
      start = (accepts < 6);
      if (can_push && start) begin
        sb.push_back(model(a, b, edge_cnt + 1, $sformatf("b2b_%0d", accepts)));
        accepts++;
        can_push = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        check_pop();
        idle_nxt = 1'b1;
      end else begin
        n_checks++;
        if (busy !== (sb.size() != 0) ||
            (sb.size() != 0 && {A_greater, A_equal, A_less} !== 3'b000)) begin
          n_fail++;
          $display("FAIL b2b_busy: got busy=%b flags=%b, want busy=%b",
                   busy, {A_greater, A_equal, A_less}, sb.size() != 0);
        end
        if (idle_nxt) begin
          idle_nxt = 1'b0;
          can_push = 1'b1;
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dones != 6 || accepts != 6 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got accepts=%0d dones=%0d pending=%0d, want 6/6/0",
               accepts, dones, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midflight();
    push_accept(8'h00, 8'h01, "abort");
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    n_checks++;
    if ({busy, done, A_greater, A_equal, A_less} !== 5'b0) begin
      n_fail++;
      $display("FAIL abort_async_clear: got busy/done/flags=%b, want 00000",
               {busy, done, A_greater, A_equal, A_less});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < D + 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: got done=%b busy=%b, want done=0 busy=0", done, busy);
      end
    end
    test_single(8'hFF, 8'h00, "after_abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    test_reset();
    test_single(8'hA5, 8'h35, "greater_msb");
    test_single(8'h3C, 8'h3C, "equal");
    test_single(8'h12, 8'h13, "less_lsb");
    test_single(8'h00, 8'hFF, "less_msb");
    test_single(8'hFF, 8'hFE, "greater_lsb");
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
